// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and index helper for irq_pending_latch.
// Used by irq_edge_detect and irq_pending_latch.
package irq_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOCK  = 2'd2
    } irq_state_e;

    function automatic logic [N_SRC-1:0] idx_onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Per-source set-term generator: rising-edge or level, selected by edge_sel.
// Holds the previous-cycle sample of the request lines.
module irq_edge_detect
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] edge_sel,
    output logic [N_SRC-1:0] set
);

    logic [N_SRC-1:0] irq_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq_in;
        end
    end

    assign set = (edge_sel & irq_in & ~irq_d) | (~edge_sel & irq_in);

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky maskable pending latch with ack-throttling FSM feeding an 8-in encoder.
// Optional sticky overflow flags when IRQ_LATCH_OVF_EN is defined.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int LOCK_CYC = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] edge_sel,
    input  logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pend_out,
    output logic             pend_valid,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic             idle,
    output logic [N_SRC-1:0] ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCK_CYC - 1);

    if (LOCK_CYC < 1 || LOCK_CYC > 15) begin : g_bad_lock
        $error("LOCK_CYC must be in 1..15");
    end

    logic [N_SRC-1:0] set;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pend_nxt;
    logic             any_out;
    logic             accept;
    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    irq_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .edge_sel (edge_sel),
        .set      (set)
    );

    assign any_out    = |pend_out;
    assign pend_valid = (state_q == ARMED) && any_out;
    assign accept     = ack && pend_valid;
    assign clr        = accept ? idx_onehot(ack_idx) : '0;

    // Set dominates clear so a same-cycle event is never lost.
    assign pend_nxt = set | (pending & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_out <= '0;
            idle     <= 1'b1;
        end else begin
            pending  <= pend_nxt;
            pend_out <= pend_nxt & ~mask;
            idle     <= ~|pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_out) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (accept) begin
                    state_d = LOCK;
                    cnt_d   = LOCK_INIT;
                end else if (!any_out) begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (cnt_q == '0) begin
                    state_d = any_out ? ARMED : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef IRQ_LATCH_OVF_EN
    logic [N_SRC-1:0] ovf_q;
    logic [N_SRC-1:0] ovf_set;

    // Only edge sources can overrun; a level line simply stays pending.
    assign ovf_set = edge_sel & set & pending & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & {N_SRC{~ovf_clr}}) | ovf_set;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = '0;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: vector table plus a priority drain.
// Expected ovf values apply only when IRQ_LATCH_OVF_EN is defined.
module tb_irq_pending_latch;

`ifdef IRQ_LATCH_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] edge_sel;
    logic [7:0] mask;
    logic [7:0] pend_out;
    logic       pend_valid;
    logic       ack;
    logic [2:0] ack_idx;
    logic       idle;
    logic [7:0] ovf;
    logic       ovf_clr;

    irq_pending_latch #(.LOCK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .edge_sel   (edge_sel),
        .mask       (mask),
        .pend_out   (pend_out),
        .pend_valid (pend_valid),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .idle       (idle),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic [7:0] esel;
        logic [7:0] msk;
        logic       ack;
        logic [2:0] idx;
        logic       oclr;
        logic [7:0] po;
        logic       pv;
        logic       idl;
        logic [7:0] ov;
    } vec_t;

    typedef struct {
        logic [7:0] po;
        logic       pv;
        logic       idl;
        logic [7:0] ov;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic [7:0] irq,
                       input logic [7:0] esel, input logic [7:0] msk,
                       input logic a, input logic [2:0] idx,
                       input logic oc, input logic [7:0] po,
                       input logic pv, input logic idl,
                       input logic [7:0] ov);
        vec_t v;
        v.rst = r;    v.irq = irq; v.esel = esel; v.msk = msk;
        v.ack = a;    v.idx = idx; v.oclr = oc;
        v.po  = po;   v.pv  = pv;  v.idl  = idl;  v.ov  = ov;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t       e;
        logic [7:0] exp_v;
        logic [2:0] top;
        int         n;

        rst = 1'b1; irq_in = '0; edge_sel = 8'hFF; mask = '0;
        ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;

        // reset and idle
        add(1,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(1,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // edge capture and ack
        add(0,8'h20,8'hFF,8'h00,0,0,0, 8'h20,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h20,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,5,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // two sources, priority sequencing
        add(0,8'h84,8'hFF,8'h00,0,0,0, 8'h84,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h84,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,7,0, 8'h04,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h04,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h04,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,2,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // level re-pend
        add(0,8'h08,8'hF7,8'h00,0,0,0, 8'h08,0,0,8'h00);
        add(0,8'h08,8'hF7,8'h00,0,0,0, 8'h08,1,0,8'h00);
        add(0,8'h08,8'hF7,8'h00,1,3,0, 8'h08,0,0,8'h00);
        add(0,8'h08,8'hF7,8'h00,0,0,0, 8'h08,0,0,8'h00);
        add(0,8'h08,8'hF7,8'h00,0,0,0, 8'h08,1,0,8'h00);
        add(0,8'h00,8'hF7,8'h00,0,0,0, 8'h08,1,0,8'h00);
        add(0,8'h00,8'hF7,8'h00,1,3,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hF7,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // mask hides but latches; masking everything drops to IDLE
        add(0,8'h10,8'hFF,8'h10,0,0,0, 8'h00,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h10,0,0,0, 8'h00,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h10,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h10,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h10,0,0,0, 8'h00,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h10,0,0,0, 8'h00,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h10,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h10,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,4,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // ack of a non-pending index still locks, no clear
        add(0,8'h02,8'hFF,8'h00,0,0,0, 8'h02,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h02,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,6,0, 8'h02,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h02,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h02,1,0,8'h00);
        // overflow, clear, clear-vs-set
        add(0,8'h02,8'hFF,8'h00,0,0,0, 8'h02,1,0,8'h02);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h02,1,0,8'h02);
        add(0,8'h00,8'hFF,8'h00,0,0,1, 8'h02,1,0,8'h00);
        add(0,8'h02,8'hFF,8'h00,0,0,1, 8'h02,1,0,8'h02);
        add(0,8'h00,8'hFF,8'h00,0,0,1, 8'h02,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,1,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // edge on the ack cycle re-pends without overflow
        add(0,8'h01,8'hFF,8'h00,0,0,0, 8'h01,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h01,1,0,8'h00);
        add(0,8'h01,8'hFF,8'h00,1,0,0, 8'h01,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h01,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h01,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,0,0, 8'h00,0,1,8'h00);
        // ack during LOCK is ignored
        add(0,8'h08,8'hFF,8'h00,1,3,0, 8'h08,0,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,3,0, 8'h08,1,0,8'h00);
        add(0,8'h00,8'hFF,8'h00,1,3,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        // level line held never overflows; reset drops it
        add(0,8'h01,8'hFE,8'h00,0,0,0, 8'h01,0,0,8'h00);
        add(0,8'h01,8'hFE,8'h00,0,0,0, 8'h01,1,0,8'h00);
        add(0,8'h01,8'hFE,8'h00,0,0,0, 8'h01,1,0,8'h00);
        add(0,8'h00,8'hFE,8'h00,0,0,0, 8'h01,1,0,8'h00);
        add(1,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);
        add(0,8'h00,8'hFF,8'h00,0,0,0, 8'h00,0,1,8'h00);

        foreach (vt[i]) begin
            rst = vt[i].rst;   irq_in = vt[i].irq;
            edge_sel = vt[i].esel; mask = vt[i].msk;
            ack = vt[i].ack;   ack_idx = vt[i].idx;
            ovf_clr = vt[i].oclr;
            e.po = vt[i].po; e.pv = vt[i].pv; e.idl = vt[i].idl;
            e.ov = OVF_ON ? vt[i].ov : 8'h00;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d_pend_out", i), pend_out, e.po);
            chk($sformatf("row%0d_pend_valid", i), {7'd0, pend_valid}, {7'd0, e.pv});
            chk($sformatf("row%0d_idle", i), {7'd0, idle}, {7'd0, e.idl});
            chk($sformatf("row%0d_ovf", i), ovf, e.ov);
        end

        // all eight at once, drained highest index first
        rst = 1'b0; mask = '0; edge_sel = 8'hFF; ack = 1'b0; ovf_clr = 1'b0;
        irq_in = 8'hFF;
        exp_v = 8'hFF;
        @(posedge clk);
        #1;
        chk("all_capture", pend_out, exp_v);
        irq_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!pend_valid && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("drain%0d_valid", k), {7'd0, pend_valid}, 8'h01);
            chk($sformatf("drain%0d_vec", k), pend_out, exp_v);
            top = '0;
            for (int b = 0; b < 8; b++) begin
                if (exp_v[b]) top = 3'(b);
            end
            ack = 1'b1; ack_idx = top;
            @(posedge clk);
            #1;
            ack = 1'b0;
            exp_v[top] = 1'b0;
            chk($sformatf("drain%0d_after", k), pend_out, exp_v);
        end
        chk("drain_idle", {7'd0, idle}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
